pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Registered control unit for the 5-stage MIPS pipeline. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, resolves BEQ/BNE in EX, squashes wrong-path instructions, flags illegal opcodes, and replaces the simulation-only BREAK stop with a drain-then-halt state machine.

## Interface
- `ALUCTRL_W`, 5 — width of the ALU operation field; codes are the `ALUOp_*` macros of ctrl_encode_def.v.
- `EXTOP_W`, 2 — width of the extend-select field; codes are `EXT_ZERO`, `EXT_SIGNED`, `EXT_HIGHPOS`.
- `REG_W`, 5 — register address width.
- `DRAIN_CYCLES`, 3 — cycles from BREAK accept to `halted`.
- `LOAD_USE_INTERLOCK`, 1 — 0 disables stall generation; the datapath then owns load-use hazards.
- `clk  in  1  clock; all state updates on the rising edge.`
- `rst_n  in  1  synchronous, active-low reset.`
- `id_valid  in  1  IF/ID register holds a real instruction.`
- `id_instr  in  32  ID-stage instruction word.`
- `ex_alu_zero  in  1  ALU zero flag of the instruction currently in EX.`
- `stall  out  1  hold PC and IF/ID; combinational.`
- `flush_ifid  out  1  clear IF/ID next edge; combinational.`
- `id_jump  out  1  J decoded in ID this cycle; combinational.`
- `ex_branch_taken  out  1  EX branch resolves taken; combinational.`
- `ex_ctrl  out  bundle  registered ID/EX control: RegDst, Alusrc, AluShift, ExtOp[EXTOP_W], Aluctrl[ALUCTRL_W], Branch, NBranch, MemR, MemW, Mem2R, RegW, waddr[REG_W].`
- `mem_ctrl  out  bundle  registered EX/MEM control: MemR, MemW, Mem2R, RegW, waddr.`
- `wb_ctrl  out  bundle  registered MEM/WB control: Mem2R, RegW, waddr.`
- `illegal  out  1  sticky; an undefined opcode or funct was accepted.`
- `halted  out  1  core halted after BREAK.`

## Operation
- Decoding uses opcode `instr[31:26]` and funct `instr[5:0]`.
  - R-type: ADDU, SUBU, SLT, SLL, SRL, SRA, AND, OR, XOR, BREAK.
  - I-type: ORI (zero-extend), LUI (`EXT_HIGHPOS`, ADDU), LW and SW (signed, ADDU), ADDI (signed, ADDU).
  - Branches: BEQ and BNE (SUBU, signed).
  - Jump: J.
- Every field is assigned on every decode path; there are no latches.
- `waddr` is rd for R-type, rt for the I-type writes and 0 for non-writers.
- SLL, SRL and SRA set AluShift.
- An all-zero instruction word is a NOP and becomes a bubble.
- A bubble is the bundle with every field 0. It is inserted into ID/EX when any of these holds: `id_valid`=0, NOP, illegal, stall, ex_branch_taken, or state≠RUN.
- Load-use hazard:
  - Condition: `ex_ctrl.MemR`=1, `ex_ctrl.waddr`≠0, and `ex_ctrl.waddr` equals a source register read by the ID instruction.
  - Source registers read: rs for everything except J, LUI and shifts; rt for R-type, SW, BEQ and BNE.
  - Response: `stall`=1 for exactly one cycle and a bubble into EX. Requires `LOAD_USE_INTERLOCK`=1.
- Branch: `ex_branch_taken` = (Branch & zero) | (NBranch & ~zero).
  - When taken: `flush_ifid`=1 and the ID instruction is replaced by a bubble.
  - Branch-taken overrides stall, J, BREAK and illegal in ID; the squashed instruction has no effect.
- Jump: `id_jump`=1 and `flush_ifid`=1, unless a stall or branch-taken is active in the same cycle.
- Illegal: a bubble is inserted and `illegal` sets.
  - `illegal` clears only on reset.
  - It is not set by a squashed or stalled-over instruction.
- State machine:
  - RUN → DRAIN on an accepted BREAK (not squashed, not stalled). The BREAK itself becomes a bubble and a counter loads `DRAIN_CYCLES`−1.
  - DRAIN: `stall`=1 and bubbles are inserted; the counter decrements; at 0 the state goes to HALTED.
  - HALTED: `halted`=1 and `stall`=1. Only reset leaves it.
  - A branch-taken from an older instruction during DRAIN still flushes.
- Register advance: ID/EX ← decode or bubble; EX/MEM ← ID/EX; MEM/WB ← EX/MEM. EX/MEM and MEM/WB always advance, including during stall.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `ex_ctrl`, `mem_ctrl` and `wb_ctrl` become all-zero.
  - State becomes RUN; `illegal`=0 and `halted`=0.
  - Combinational outputs then read 0 when the inputs are idle.
  - Reset mid-DRAIN or while HALTED returns to RUN on the next edge.
- Decode-to-`ex_ctrl` latency is 1 cycle; `mem_ctrl` follows at 2 cycles and `wb_ctrl` at 3.
- `stall`, `flush_ifid`, `id_jump` and `ex_branch_taken` are same-cycle combinational outputs from registered state and ID inputs.
- Load-use costs exactly 1 bubble; the dependent instruction enters EX the following cycle.
- Taken branch costs 2 squashed slots: the ID instruction and the IF fetch.
- J costs 1 slot.
- `halted` rises `DRAIN_CYCLES` edges after the BREAK edge. All older instructions have left WB by then.

## Test plan
- Reset sequence: `rst_n`=0 for 2 cycles, then 1 → all bundles 0, `halted`=0, `illegal`=0.
- Decode check: ADDU $3,$1,$2 then LW $4,0($3) → `ex_ctrl` shows RegW=1, waddr=3, Aluctrl=`ALUOp_ADDU` at +1; `wb_ctrl` shows Mem2R=1, waddr=4 at +4.
- Load-use: LW $5,0($0) followed by ADDU $6,$5,$1 → `stall`=1 for one cycle, then a bubble in EX; ADDU reaches `ex_ctrl` 2 cycles after LW. Repeat with destination $0 → no stall.
- Branch: BEQ with `ex_alu_zero`=1 while J is in ID → `ex_branch_taken`=1, `flush_ifid`=1, `id_jump`=0, and the next `ex_ctrl` is a bubble. Repeat with `ex_alu_zero`=0 → no flush. Repeat BNE with the zero flag inverted.
- Illegal: opcode 6'b111111 → bubble and `illegal`=1, which persists until reset.
- BREAK: ORI, BREAK, ADDU → ADDU is never decoded, `halted` rises 3 edges after BREAK, and `stall` stays 1. Assert reset during DRAIN → state returns to RUN and `halted` stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage MIPS core: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use interlock, EX branch resolve/squash, illegal flag and BREAK drain-then-halt.
module pipe_ctrl #(
  parameter int unsigned ALUCTRL_W          = 5,
  parameter int unsigned EXTOP_W            = 2,
  parameter int unsigned REG_W              = 5,
  parameter int unsigned DRAIN_CYCLES       = 3,
  parameter bit          LOAD_USE_INTERLOCK = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               id_valid_i,
  input  logic [31:0]                        id_instr_i,
  input  logic                               ex_alu_zero_i,
  output logic                               stall_o,
  output logic                               flush_ifid_o,
  output logic                               id_jump_o,
  output logic                               ex_branch_taken_o,
  // {RegDst, Alusrc, AluShift, ExtOp, Aluctrl, Branch, NBranch, MemR, MemW, Mem2R, RegW, waddr}
  output logic [ALUCTRL_W+EXTOP_W+REG_W+8:0] ex_ctrl_o,
  // {MemR, MemW, Mem2R, RegW, waddr}
  output logic [REG_W+3:0]                   mem_ctrl_o,
  // {Mem2R, RegW, waddr}
  output logic [REG_W+1:0]                   wb_ctrl_o,
  output logic                               illegal_o,
  output logic                               halted_o
);

  typedef struct packed {
    logic                 reg_dst;
    logic                 alu_src;
    logic                 alu_shift;
    logic [EXTOP_W-1:0]   ext_op;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 branch;
    logic                 nbranch;
    logic                 mem_r;
    logic                 mem_w;
    logic                 mem2r;
    logic                 reg_w;
    logic [REG_W-1:0]     waddr;
  } ex_ctrl_t;

  typedef struct packed {
    logic             mem_r;
    logic             mem_w;
    logic             mem2r;
    logic             reg_w;
    logic [REG_W-1:0] waddr;
  } mem_ctrl_t;

  typedef struct packed {
    logic             mem2r;
    logic             reg_w;
    logic [REG_W-1:0] waddr;
  } wb_ctrl_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam int unsigned CntW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [5:0] OpRtype = 6'h00, OpJ   = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08, OpOri = 6'h0d, OpLui = 6'h0f, OpLw  = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00, FnSrl  = 6'h02, FnSra = 6'h03, FnBreak = 6'h0d;
  localparam logic [5:0] FnAddu = 6'h21, FnSubu = 6'h23, FnAnd = 6'h24, FnOr    = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26, FnSlt  = 6'h2a;

  localparam logic [ALUCTRL_W-1:0] AluAddu = ALUCTRL_W'(1), AluSubu = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] AluAnd  = ALUCTRL_W'(3), AluOr   = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] AluXor  = ALUCTRL_W'(5), AluSlt  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] AluSll  = ALUCTRL_W'(7), AluSrl  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] AluSra  = ALUCTRL_W'(9);

  localparam logic [EXTOP_W-1:0] ExtZero    = EXTOP_W'(0);
  localparam logic [EXTOP_W-1:0] ExtSigned  = EXTOP_W'(1);
  localparam logic [EXTOP_W-1:0] ExtHighpos = EXTOP_W'(2);

  ex_ctrl_t  ex_q, ex_d, dec;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  state_e    state_q;
  logic [CntW-1:0] cnt_q;
  logic      illegal_q, halted_q;

  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] rs, rt, rd;
  logic is_j, is_break, is_illegal, uses_rs, uses_rt, is_nop;
  logic load_use, taken, running, accept;
  logic unused_shamt;

  assign opcode       = id_instr_i[31:26];
  assign funct        = id_instr_i[5:0];
  assign rs           = REG_W'(id_instr_i[25:21]);
  assign rt           = REG_W'(id_instr_i[20:16]);
  assign rd           = REG_W'(id_instr_i[15:11]);
  assign unused_shamt = ^id_instr_i[10:6];
  assign is_nop       = (id_instr_i == 32'd0);

  always_comb begin
    dec        = '0;
    is_j       = 1'b0;
    is_break   = 1'b0;
    is_illegal = 1'b0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    case (opcode)
      OpRtype: begin
        dec.reg_dst = 1'b1;
        dec.reg_w   = 1'b1;
        dec.waddr   = rd;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        case (funct)
          FnAddu:  dec.alu_ctrl = AluAddu;
          FnSubu:  dec.alu_ctrl = AluSubu;
          FnSlt:   dec.alu_ctrl = AluSlt;
          FnAnd:   dec.alu_ctrl = AluAnd;
          FnOr:    dec.alu_ctrl = AluOr;
          FnXor:   dec.alu_ctrl = AluXor;
          FnSll:   begin dec.alu_ctrl = AluSll; dec.alu_shift = 1'b1; uses_rs = 1'b0; end
          FnSrl:   begin dec.alu_ctrl = AluSrl; dec.alu_shift = 1'b1; uses_rs = 1'b0; end
          FnSra:   begin dec.alu_ctrl = AluSra; dec.alu_shift = 1'b1; uses_rs = 1'b0; end
          FnBreak: begin dec = '0; is_break = 1'b1; end
          default: begin dec = '0; is_illegal = 1'b1; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OpOri: begin
        dec.alu_src = 1'b1; dec.ext_op = ExtZero; dec.alu_ctrl = AluOr;
        dec.reg_w   = 1'b1; dec.waddr  = rt;      uses_rs      = 1'b1;
      end
      OpLui: begin
        dec.alu_src = 1'b1; dec.ext_op = ExtHighpos; dec.alu_ctrl = AluAddu;
        dec.reg_w   = 1'b1; dec.waddr  = rt;
      end
      OpLw: begin
        dec.alu_src = 1'b1; dec.ext_op = ExtSigned; dec.alu_ctrl = AluAddu;
        dec.mem_r   = 1'b1; dec.mem2r  = 1'b1;      dec.reg_w    = 1'b1;
        dec.waddr   = rt;   uses_rs    = 1'b1;
      end
      OpSw: begin
        dec.alu_src = 1'b1; dec.ext_op = ExtSigned; dec.alu_ctrl = AluAddu;
        dec.mem_w   = 1'b1; uses_rs    = 1'b1;      uses_rt      = 1'b1;
      end
      OpAddi: begin
        dec.alu_src = 1'b1; dec.ext_op = ExtSigned; dec.alu_ctrl = AluAddu;
        dec.reg_w   = 1'b1; dec.waddr  = rt;        uses_rs      = 1'b1;
      end
      OpBeq: begin
        dec.ext_op = ExtSigned; dec.alu_ctrl = AluSubu; dec.branch = 1'b1;
        uses_rs    = 1'b1;      uses_rt      = 1'b1;
      end
      OpBne: begin
        dec.ext_op = ExtSigned; dec.alu_ctrl = AluSubu; dec.nbranch = 1'b1;
        uses_rs    = 1'b1;      uses_rt      = 1'b1;
      end
      OpJ:     is_j       = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  assign running  = (state_q == StRun);
  assign taken    = (ex_q.branch & ex_alu_zero_i) | (ex_q.nbranch & ~ex_alu_zero_i);
  assign load_use = LOAD_USE_INTERLOCK && id_valid_i && ex_q.mem_r && (ex_q.waddr != '0) &&
                    ((uses_rs && (ex_q.waddr == rs)) || (uses_rt && (ex_q.waddr == rt)));

  // A taken branch squashes the ID instruction, so its hazard must not hold the PC.
  assign stall_o           = ~running | (load_use & ~taken);
  assign id_jump_o         = id_valid_i & is_j & ~stall_o & ~taken;
  assign flush_ifid_o      = taken | id_jump_o;
  assign ex_branch_taken_o = taken;
  assign accept            = id_valid_i & running & ~taken & ~load_use;

  always_comb begin
    ex_d = '0;
    if (accept && !is_nop && !is_illegal && !is_break) begin
      ex_d = dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= StRun;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q.mem_r <= ex_q.mem_r;
      mem_q.mem_w <= ex_q.mem_w;
      mem_q.mem2r <= ex_q.mem2r;
      mem_q.reg_w <= ex_q.reg_w;
      mem_q.waddr <= ex_q.waddr;
      wb_q.mem2r  <= mem_q.mem2r;
      wb_q.reg_w  <= mem_q.reg_w;
      wb_q.waddr  <= mem_q.waddr;
      if (accept && is_illegal) begin
        illegal_q <= 1'b1;
      end
      case (state_q)
        StRun: begin
          if (accept && is_break) begin
            state_q <= StDrain;
            cnt_q   <= CntW'(DRAIN_CYCLES - 1);
          end
        end
        StDrain: begin
          if (cnt_q == '0) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHalted: halted_q <= 1'b1;
        default:  state_q  <= StRun;
      endcase
    end
  end

  assign ex_ctrl_o  = ex_q;
  assign mem_ctrl_o = mem_q;
  assign wb_ctrl_o  = wb_q;
  assign illegal_o  = illegal_q;
  assign halted_o   = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: decode, load-use, branch/jump, illegal, BREAK halt.
module tb_pipe_ctrl;

  logic        clk, rst_n, id_valid, ex_alu_zero;
  logic [31:0] id_instr;
  logic        stall, flush_ifid, id_jump, ex_branch_taken, illegal, halted;
  logic [20:0] ex_ctrl;
  logic [8:0]  mem_ctrl;
  logic [6:0]  wb_ctrl;
  int          checks, failures;

  localparam logic [4:0] ALU_ADDU = 5'd1, ALU_SUBU = 5'd2, ALU_OR = 5'd4, ALU_SRA = 5'd9;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGNED = 2'd1;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ORI = 6'h0d, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SRA = 6'h03, FN_BREAK = 6'h0d;
  localparam logic [31:0] J_INSTR = {6'h02, 26'h40};
  localparam logic [31:0] BAD_OP  = 32'hfc00_0000;

  pipe_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .id_valid_i       (id_valid),
    .id_instr_i       (id_instr),
    .ex_alu_zero_i    (ex_alu_zero),
    .stall_o          (stall),
    .flush_ifid_o     (flush_ifid),
    .id_jump_o        (id_jump),
    .ex_branch_taken_o(ex_branch_taken),
    .ex_ctrl_o        (ex_ctrl),
    .mem_ctrl_o       (mem_ctrl),
    .wb_ctrl_o        (wb_ctrl),
    .illegal_o        (illegal),
    .halted_o         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk_ex(input logic rdst, asrc, sh, input logic [1:0] ext,
                                        input logic [4:0] alu, input logic br, nb, mr, mw,
                                        m2r, rw, input logic [4:0] wa);
    return {rdst, asrc, sh, ext, alu, br, nb, mr, mw, m2r, rw, wa};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic z);
    id_valid    = v;
    id_instr    = instr;
    ex_alu_zero = z;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 32'd0, 1'b0);
    checks++; if (ex_ctrl !== 21'd0) begin failures++; $display("FAIL rst_ex got=%h exp=0", ex_ctrl); end
    checks++; if (mem_ctrl !== 9'd0) begin failures++; $display("FAIL rst_mem got=%h exp=0", mem_ctrl); end
    checks++; if (wb_ctrl !== 7'd0) begin failures++; $display("FAIL rst_wb got=%h exp=0", wb_ctrl); end
    checks++; if ({illegal, halted} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {illegal, halted}); end
    checks++; if ({stall, flush_ifid, id_jump, ex_branch_taken} !== 4'b0000) begin
      failures++; $display("FAIL rst_comb got=%b exp=0000", {stall, flush_ifid, id_jump, ex_branch_taken});
    end
  endtask

  task automatic test_decode();
    logic [20:0] e_addu, e_lw, e_sra, e_sw;
    e_addu = mk_ex(1'b1, 1'b0, 1'b0, EXT_ZERO, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    e_lw   = mk_ex(1'b0, 1'b1, 1'b0, EXT_SIGNED, ALU_ADDU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    e_sra  = mk_ex(1'b1, 1'b0, 1'b1, EXT_ZERO, ALU_SRA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    e_sw   = mk_ex(1'b0, 1'b1, 1'b0, EXT_SIGNED, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    do_reset();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_addu) begin failures++; $display("FAIL dec_addu_ex got=%h exp=%h", ex_ctrl, e_addu); end
    drive(1'b1, itype(OP_LW, 5'd3, 5'd4, 16'd0), 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dec_no_stall got=%b exp=0", stall); end
    cyc();
    checks++; if (ex_ctrl !== e_lw) begin failures++; $display("FAIL dec_lw_ex got=%h exp=%h", ex_ctrl, e_lw); end
    checks++; if (mem_ctrl !== {4'b0001, 5'd3}) begin failures++; $display("FAIL dec_addu_mem got=%h exp=%h", mem_ctrl, {4'b0001, 5'd3}); end
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    checks++; if (wb_ctrl !== {2'b01, 5'd3}) begin failures++; $display("FAIL dec_addu_wb got=%h exp=%h", wb_ctrl, {2'b01, 5'd3}); end
    checks++; if (mem_ctrl !== {4'b1011, 5'd4}) begin failures++; $display("FAIL dec_lw_mem got=%h exp=%h", mem_ctrl, {4'b1011, 5'd4}); end
    cyc();
    checks++; if (wb_ctrl !== {2'b11, 5'd4}) begin failures++; $display("FAIL dec_lw_wb got=%h exp=%h", wb_ctrl, {2'b11, 5'd4}); end
    drive(1'b1, rtype(5'd0, 5'd2, 5'd7, FN_SRA), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_sra) begin failures++; $display("FAIL dec_sra_ex got=%h exp=%h", ex_ctrl, e_sra); end
    drive(1'b1, itype(OP_SW, 5'd1, 5'd2, 16'h0008), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_sw) begin failures++; $display("FAIL dec_sw_ex got=%h exp=%h", ex_ctrl, e_sw); end
  endtask

  task automatic test_load_use();
    logic [20:0] e_lw5, e_addu6;
    e_lw5   = mk_ex(1'b0, 1'b1, 1'b0, EXT_SIGNED, ALU_ADDU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    e_addu6 = mk_ex(1'b1, 1'b0, 1'b0, EXT_ZERO, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    do_reset();
    drive(1'b1, itype(OP_LW, 5'd0, 5'd5, 16'd0), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_lw5) begin failures++; $display("FAIL lu_lw_ex got=%h exp=%h", ex_ctrl, e_lw5); end
    drive(1'b1, rtype(5'd5, 5'd1, 5'd6, FN_ADDU), 1'b0);
    checks++; if ({stall, flush_ifid} !== 2'b10) begin failures++; $display("FAIL lu_stall got=%b exp=10", {stall, flush_ifid}); end
    cyc();
    checks++; if (ex_ctrl !== 21'd0) begin failures++; $display("FAIL lu_bubble got=%h exp=0", ex_ctrl); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall); end
    cyc();
    checks++; if (ex_ctrl !== e_addu6) begin failures++; $display("FAIL lu_addu_ex got=%h exp=%h", ex_ctrl, e_addu6); end
    checks++; if (wb_ctrl !== {2'b11, 5'd5}) begin failures++; $display("FAIL lu_lw_wb got=%h exp=%h", wb_ctrl, {2'b11, 5'd5}); end
    drive(1'b1, itype(OP_LW, 5'd0, 5'd7, 16'd4), 1'b0);
    cyc();
    drive(1'b1, rtype(5'd1, 5'd7, 5'd8, FN_ADDU), 1'b0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_rt_stall got=%b exp=1", stall); end
    cyc();
    cyc();
    drive(1'b1, itype(OP_LW, 5'd0, 5'd0, 16'd0), 1'b0);
    cyc();
    drive(1'b1, rtype(5'd0, 5'd1, 5'd6, FN_ADDU), 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_r0_nostall got=%b exp=0", stall); end
    cyc();
    checks++; if (ex_ctrl !== e_addu6) begin failures++; $display("FAIL lu_r0_ex got=%h exp=%h", ex_ctrl, e_addu6); end
  endtask

  task automatic test_branch();
    logic [20:0] e_beq, e_bne, e_addu;
    e_beq  = mk_ex(1'b0, 1'b0, 1'b0, EXT_SIGNED, ALU_SUBU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    e_bne  = mk_ex(1'b0, 1'b0, 1'b0, EXT_SIGNED, ALU_SUBU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    e_addu = mk_ex(1'b1, 1'b0, 1'b0, EXT_ZERO, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    do_reset();
    drive(1'b1, itype(OP_BEQ, 5'd1, 5'd2, 16'd4), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_beq) begin failures++; $display("FAIL br_beq_ex got=%h exp=%h", ex_ctrl, e_beq); end
    drive(1'b1, J_INSTR, 1'b1);
    checks++; if ({ex_branch_taken, flush_ifid, id_jump, stall} !== 4'b1100) begin
      failures++; $display("FAIL br_beq_taken got=%b exp=1100", {ex_branch_taken, flush_ifid, id_jump, stall});
    end
    cyc();
    checks++; if (ex_ctrl !== 21'd0) begin failures++; $display("FAIL br_squash_bubble got=%h exp=0", ex_ctrl); end
    drive(1'b1, itype(OP_BEQ, 5'd1, 5'd2, 16'd4), 1'b0);
    cyc();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b0);
    checks++; if ({ex_branch_taken, flush_ifid} !== 2'b00) begin failures++; $display("FAIL br_beq_nt got=%b exp=00", {ex_branch_taken, flush_ifid}); end
    cyc();
    checks++; if (ex_ctrl !== e_addu) begin failures++; $display("FAIL br_nt_ex got=%h exp=%h", ex_ctrl, e_addu); end
    drive(1'b1, J_INSTR, 1'b0);
    checks++; if ({id_jump, flush_ifid} !== 2'b11) begin failures++; $display("FAIL br_jump got=%b exp=11", {id_jump, flush_ifid}); end
    cyc();
    checks++; if (ex_ctrl !== 21'd0) begin failures++; $display("FAIL br_jump_ex got=%h exp=0", ex_ctrl); end
    drive(1'b1, itype(OP_BNE, 5'd1, 5'd2, 16'd8), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_bne) begin failures++; $display("FAIL br_bne_ex got=%h exp=%h", ex_ctrl, e_bne); end
    drive(1'b1, BAD_OP, 1'b0);
    checks++; if ({ex_branch_taken, flush_ifid} !== 2'b11) begin failures++; $display("FAIL br_bne_taken got=%b exp=11", {ex_branch_taken, flush_ifid}); end
    cyc();
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL br_squash_illegal got=%b exp=0", illegal); end
    drive(1'b1, itype(OP_BNE, 5'd1, 5'd2, 16'd8), 1'b0);
    cyc();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b1);
    checks++; if ({ex_branch_taken, flush_ifid} !== 2'b00) begin failures++; $display("FAIL br_bne_nt got=%b exp=00", {ex_branch_taken, flush_ifid}); end
    cyc();
  endtask

  task automatic test_illegal();
    logic [20:0] e_addu;
    e_addu = mk_ex(1'b1, 1'b0, 1'b0, EXT_ZERO, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    do_reset();
    drive(1'b1, BAD_OP, 1'b0);
    cyc();
    checks++; if (ex_ctrl !== 21'd0) begin failures++; $display("FAIL ill_bubble got=%h exp=0", ex_ctrl); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_set got=%b exp=1", illegal); end
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b0);
    cyc();
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    cyc();
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_sticky got=%b exp=1", illegal); end
    checks++; if (wb_ctrl !== {2'b01, 5'd3}) begin failures++; $display("FAIL ill_next_wb got=%h exp=%h", wb_ctrl, {2'b01, 5'd3}); end
    do_reset();
    drive(1'b0, 32'd0, 1'b0);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_reset got=%b exp=0", illegal); end
  endtask

  task automatic test_break();
    logic [20:0] e_ori, e_addu;
    logic [31:0] brk;
    e_ori  = mk_ex(1'b0, 1'b1, 1'b0, EXT_ZERO, ALU_OR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    e_addu = mk_ex(1'b1, 1'b0, 1'b0, EXT_ZERO, ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    brk    = rtype(5'd0, 5'd0, 5'd0, FN_BREAK);
    do_reset();
    drive(1'b1, itype(OP_ORI, 5'd0, 5'd2, 16'd5), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_ori) begin failures++; $display("FAIL brk_ori_ex got=%h exp=%h", ex_ctrl, e_ori); end
    drive(1'b1, brk, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL brk_accept got=%b exp=0", stall); end
    cyc();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b0);
    checks++; if ({ex_ctrl == 21'd0, stall, halted} !== 3'b110) begin
      failures++; $display("FAIL brk_drain0 got=%b exp=110", {ex_ctrl == 21'd0, stall, halted});
    end
    cyc();
    checks++; if (wb_ctrl !== {2'b01, 5'd2}) begin failures++; $display("FAIL brk_ori_wb got=%h exp=%h", wb_ctrl, {2'b01, 5'd2}); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL brk_drain1 got=%b exp=0", halted); end
    cyc();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL brk_drain2 got=%b exp=0", halted); end
    cyc();
    checks++; if ({halted, stall} !== 2'b11) begin failures++; $display("FAIL brk_halt got=%b exp=11", {halted, stall}); end
    cyc();
    cyc();
    checks++; if ({ex_ctrl == 21'd0, halted, stall} !== 3'b111) begin
      failures++; $display("FAIL brk_held got=%b exp=111", {ex_ctrl == 21'd0, halted, stall});
    end
    do_reset();
    drive(1'b0, 32'd0, 1'b0);
    checks++; if ({halted, stall} !== 2'b00) begin failures++; $display("FAIL brk_halt_reset got=%b exp=00", {halted, stall}); end
    drive(1'b1, brk, 1'b0);
    cyc();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL brk2_drain got=%b exp=1", stall); end
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    checks++; if ({halted, stall} !== 2'b00) begin failures++; $display("FAIL brk2_reset got=%b exp=00", {halted, stall}); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if ({halted, stall} !== 2'b00) begin failures++; $display("FAIL brk2_run got=%b exp=00", {halted, stall}); end
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, FN_ADDU), 1'b0);
    cyc();
    checks++; if (ex_ctrl !== e_addu) begin failures++; $display("FAIL brk2_addu_ex got=%h exp=%h", ex_ctrl, e_addu); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_instr    = 32'd0;
    ex_alu_zero = 1'b0;
    test_reset();
    test_decode();
    test_load_use();
    test_branch();
    test_illegal();
    test_break();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
